// File: rtl/work_pkg.sv
// Shared constants and FSM state type for the word-serial work-loading transmitter.
package work_pkg;

  localparam int WORD_W      = 32;
  localparam int MID_WORDS   = 8;
  localparam int REM_WORDS   = 16;
  localparam int TOTAL_WORDS = MID_WORDS + REM_WORDS;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int CNT_W = $clog2(max_int(MID_WORDS, REM_WORDS));

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_MID   = 3'd2,
    ST_REM   = 3'd3,
    ST_DONE  = 3'd4
  } tx_state_t;

endpackage

// File: rtl/word_mux_counter.sv
// Word counter with clear/enable and terminal flag, plus the word-select mux
// over the captured packet (word 0 sits in the most-significant bits).
module word_mux_counter
  import work_pkg::*;
#(
  parameter int W_W   = WORD_W,
  parameter int MID_N = MID_WORDS,
  parameter int REM_N = REM_WORDS,
  parameter int CW    = CNT_W
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       clr,
  input  logic                       en,
  input  logic                       sel_rem,
  input  logic [(MID_N+REM_N)*W_W-1:0] pkt,
  output logic [CW-1:0]              count,
  output logic                       last,
  output logic [W_W-1:0]             word
);

  localparam int TOT_N = MID_N + REM_N;
  localparam int IDX_W = $clog2(TOT_N);

  logic [CW-1:0]    count_q, count_d;
  logic [IDX_W-1:0] idx;
  logic [W_W-1:0]   words [TOT_N];

  always_comb begin
    count_d = count_q;
    if (clr)     count_d = '0;
    else if (en) count_d = count_q + CW'(1);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) count_q <= '0;
    else        count_q <= count_d;
  end

  // Terminal values are compared explicitly; the counter is cleared, never wrapped.
  assign last = sel_rem ? (count_q == CW'(REM_N - 1)) : (count_q == CW'(MID_N - 1));

  for (genvar i = 0; i < TOT_N; i++) begin : g_words
    assign words[i] = pkt[(TOT_N-1-i)*W_W +: W_W];
  end

  assign idx   = sel_rem ? (IDX_W'(MID_N) + IDX_W'(count_q)) : IDX_W'(count_q);
  assign word  = words[idx];
  assign count = count_q;

endmodule

// File: rtl/work_shift_tx.sv
// Transmit side of the word-serial work-loading interface: start marker, then
// 8 midstate words and 16 block words under dest_ready back-pressure.
// Handshake: a word transfers on every cycle where shift_out_enable=1, which is
// exactly dest_ready while in MID/REM; shift_data holds until that transfer.
module work_shift_tx
  import work_pkg::*;
#(
  parameter int WORD_W_P    = WORD_W,
  parameter int MID_WORDS_P = MID_WORDS,
  parameter int REM_WORDS_P = REM_WORDS
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          load_valid,
  output logic                          load_ready,
  input  logic [MID_WORDS_P*WORD_W_P-1:0] midstate,
  input  logic [REM_WORDS_P*WORD_W_P-1:0] block_data,
  input  logic                          abort,
  input  logic                          dest_ready,
  output logic                          start_found,
  output logic                          shift_out_enable,
  output logic [WORD_W_P-1:0]           shift_data,
  output logic                          midstate_shifts_done,
  output logic                          remaining_shifts_done,
  output logic                          busy
);

  localparam int TOT_N = MID_WORDS_P + REM_WORDS_P;
  localparam int CW    = $clog2(max_int(MID_WORDS_P, REM_WORDS_P));

  tx_state_t               state_q, state_d;
  logic [TOT_N*WORD_W_P-1:0] pkt_q, pkt_d;
  logic                    mid_done_q, mid_done_d;

  logic                    in_data, xfer, cnt_clr, cnt_last, sel_rem;
  logic [CW-1:0]           cnt;
  logic [WORD_W_P-1:0]     cur_word;

  assign in_data = (state_q == ST_MID) || (state_q == ST_REM);
  assign xfer    = in_data && dest_ready;
  assign sel_rem = (state_q == ST_REM);

  always_comb begin
    state_d    = state_q;
    pkt_d      = pkt_q;
    mid_done_d = 1'b0;
    cnt_clr    = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (load_valid) begin
          pkt_d   = {midstate, block_data};
          state_d = ST_START;
        end
      end
      ST_START: begin
        state_d = abort ? ST_IDLE : ST_MID;
      end
      ST_MID: begin
        cnt_clr = abort || (xfer && cnt_last);
        if (abort) begin
          state_d = ST_IDLE;
        end else if (xfer && cnt_last) begin
          state_d    = ST_REM;
          mid_done_d = 1'b1;
        end
      end
      ST_REM: begin
        cnt_clr = abort || (xfer && cnt_last);
        if (abort)                 state_d = ST_IDLE;
        else if (xfer && cnt_last) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= ST_IDLE;
      pkt_q      <= '0;
      mid_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pkt_q      <= pkt_d;
      mid_done_q <= mid_done_d;
    end
  end

  word_mux_counter #(
    .W_W   (WORD_W_P),
    .MID_N (MID_WORDS_P),
    .REM_N (REM_WORDS_P),
    .CW    (CW)
  ) u_word_mux_counter (
    .clk     (clk),
    .n_rst   (n_rst),
    .clr     (cnt_clr),
    .en      (xfer),
    .sel_rem (sel_rem),
    .pkt     (pkt_q),
    .count   (cnt),
    .last    (cnt_last),
    .word    (cur_word)
  );

  assign load_ready            = (state_q == ST_IDLE);
  assign start_found           = (state_q == ST_START);
  assign shift_out_enable      = xfer;
  assign shift_data            = in_data ? cur_word : '0;
  assign midstate_shifts_done  = mid_done_q;
  assign remaining_shifts_done = (state_q == ST_DONE);
  assign busy                  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_work_shift_tx.sv
// Directed bench for work_shift_tx: a per-cycle vector table for the full-rate
// packet, then hand sequences for back-pressure, abort, reset, ignored load and back-to-back.
module tb_work_shift_tx;
  import work_pkg::*;

  localparam int W  = WORD_W;
  localparam int MN = MID_WORDS;
  localparam int RN = REM_WORDS;
  localparam int TN = TOTAL_WORDS;

  logic              clk, n_rst;
  logic              load_valid, load_ready, abort, dest_ready;
  logic [MN*W-1:0]   midstate;
  logic [RN*W-1:0]   block_data;
  logic              start_found, shift_out_enable, midstate_shifts_done;
  logic              remaining_shifts_done, busy;
  logic [W-1:0]      shift_data;

  work_shift_tx dut (
    .clk                   (clk),
    .n_rst                 (n_rst),
    .load_valid            (load_valid),
    .load_ready            (load_ready),
    .midstate              (midstate),
    .block_data            (block_data),
    .abort                 (abort),
    .dest_ready            (dest_ready),
    .start_found           (start_found),
    .shift_out_enable      (shift_out_enable),
    .shift_data            (shift_data),
    .midstate_shifts_done  (midstate_shifts_done),
    .remaining_shifts_done (remaining_shifts_done),
    .busy                  (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic         lv, dr;
    logic         e_start, e_en, e_md, e_rd, e_lr, e_busy;
    logic [W-1:0] e_data;
  } vec_t;
  vec_t vecs[28];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    n_rst = 1'b0; load_valid = 1'b0; dest_ready = 1'b0; abort = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_load_ready", load_ready, 1);
    chk("rst_start", start_found, 0);
    chk("rst_en", shift_out_enable, 0);
    chk("rst_data", shift_data, 0);
    chk("rst_done", {midstate_shifts_done, remaining_shifts_done, busy}, 0);
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  function automatic logic [W-1:0] pkt_word(input logic [MN*W-1:0] m,
                                            input logic [RN*W-1:0] b, input int i);
    logic [TN*W-1:0] p;
    p = {m, b};
    return p[(TN-1-i)*W +: W];
  endfunction

  // Sends one packet from IDLE and scores every cycle. dr_mode 1 = 1,0,0,1 pattern.
  // abort_word >= 0 aborts on the transfer of that word; junk_at >= 0 pulses a load then.
  task automatic run_pkt(input logic [MN*W-1:0] m, input logic [RN*W-1:0] b,
                         input int dr_mode, input int abort_word, input int junk_at);
    int  cyc, sent;
    logic mexp, aborted;
    exp_q.delete();
    for (int i = 0; i < TN; i++) exp_q.push_back(pkt_word(m, b, i));
    #1;
    chk("pkt_load_ready", load_ready, 1);
    load_valid = 1'b1; midstate = m; block_data = b;
    @(negedge clk);
    load_valid = 1'b0;
    dest_ready = (dr_mode == 0);
    #1;
    chk("pkt_start", start_found, 1);
    chk("pkt_start_en", shift_out_enable, 0);
    chk("pkt_start_busy", {busy, load_ready}, 2'b10);
    @(negedge clk);
    cyc = 0; sent = 0; mexp = 1'b0; aborted = 1'b0;
    while (exp_q.size() > 0 && cyc < 400 && !aborted) begin
      dest_ready = (dr_mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      abort = (sent == abort_word) && dest_ready;
      if (sent == junk_at) begin
        load_valid = 1'b1; midstate = ~m; block_data = ~b;
      end
      #1;
      chk("data", shift_data, exp_q[0]);
      chk("en", shift_out_enable, dest_ready);
      chk("mid_done", midstate_shifts_done, mexp);
      chk("busy_lr", {busy, load_ready, start_found, remaining_shifts_done}, 4'b1000);
      mexp = 1'b0;
      if (dest_ready) begin
        void'(exp_q.pop_front());
        sent++;
        if (abort) aborted = 1'b1;
        else if (sent == MN) mexp = 1'b1;
      end
      @(negedge clk);
      abort = 1'b0; load_valid = 1'b0;
      cyc++;
    end
    if (cyc >= 400) chk("timeout", 0, 1);
    dest_ready = 1'b1;
    #1;
    if (aborted) begin
      chk("abort_idle", {busy, load_ready}, 2'b01);
      chk("abort_no_done", {midstate_shifts_done, remaining_shifts_done}, 0);
      chk("abort_en", shift_out_enable, 0);
      @(negedge clk);
    end else begin
      chk("done_pulse", remaining_shifts_done, 1);
      chk("done_en_data", {shift_out_enable, shift_data}, 0);
      chk("done_busy", {busy, load_ready, midstate_shifts_done}, 3'b100);
      @(negedge clk);
      #1;
      chk("after_done", {busy, load_ready, remaining_shifts_done}, 3'b010);
    end
    dest_ready = 1'b0;
  endtask

  logic [MN*W-1:0] m1, m2;
  logic [RN*W-1:0] b1, b2;
  int starts[3];
  int ns;

  initial begin
    for (int i = 0; i < MN; i++) m1[(MN-1-i)*W +: W] = 32'h1 + 32'(i);
    for (int i = 0; i < RN; i++) b1[(RN-1-i)*W +: W] = 32'h11 + 32'(i);
    for (int i = 0; i < MN; i++) m2[(MN-1-i)*W +: W] = 32'hA5A5A500 + 32'(i);
    for (int i = 0; i < RN; i++) b2[(RN-1-i)*W +: W] = 32'hA5A5A5A5 ^ 32'(i << 4);
    midstate = '0; block_data = '0;

    // Full-rate vector table: IDLE/load, START, 24 words, DONE, IDLE.
    vecs[0] = '{lv:1, dr:1, e_start:0, e_en:0, e_md:0, e_rd:0, e_lr:1, e_busy:0, e_data:0};
    vecs[1] = '{lv:0, dr:1, e_start:1, e_en:0, e_md:0, e_rd:0, e_lr:0, e_busy:1, e_data:0};
    for (int i = 0; i < TN; i++)
      vecs[2+i] = '{lv:0, dr:1, e_start:0, e_en:1, e_md:(i == MN), e_rd:0, e_lr:0, e_busy:1,
                    e_data:((i < MN) ? 32'(i + 1) : 32'(32'h11 + i - MN))};
    vecs[26] = '{lv:0, dr:1, e_start:0, e_en:0, e_md:0, e_rd:1, e_lr:0, e_busy:1, e_data:0};
    vecs[27] = '{lv:0, dr:1, e_start:0, e_en:0, e_md:0, e_rd:0, e_lr:1, e_busy:0, e_data:0};

    do_reset();
    midstate = m1; block_data = b1;
    for (int v = 0; v < 28; v++) begin
      load_valid = vecs[v].lv; dest_ready = vecs[v].dr; abort = 1'b0;
      #1;
      chk($sformatf("vec%0d_start", v), start_found, vecs[v].e_start);
      chk($sformatf("vec%0d_en", v), shift_out_enable, vecs[v].e_en);
      chk($sformatf("vec%0d_data", v), shift_data, vecs[v].e_data);
      chk($sformatf("vec%0d_mdone", v), midstate_shifts_done, vecs[v].e_md);
      chk($sformatf("vec%0d_rdone", v), remaining_shifts_done, vecs[v].e_rd);
      chk($sformatf("vec%0d_lready", v), load_ready, vecs[v].e_lr);
      chk($sformatf("vec%0d_busy", v), busy, vecs[v].e_busy);
      @(negedge clk);
    end
    load_valid = 1'b0; dest_ready = 1'b0;

    // Back-pressure, then abort mid-REM at block word 5, then a fresh packet.
    run_pkt(m1, b1, 1, -1, -1);
    run_pkt(m1, b1, 0, MN + 5, -1);
    run_pkt(m2, b2, 0, -1, -1);

    // Asynchronous reset while midstate word 3 is on the wire.
    load_valid = 1'b1; midstate = m1; block_data = b1;
    @(negedge clk);
    load_valid = 1'b0; dest_ready = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk("pre_rst_word3", shift_data, 32'h4);
    n_rst = 1'b0;
    #1;
    chk("async_rst_lr", load_ready, 1);
    chk("async_rst_outs", {start_found, shift_out_enable, midstate_shifts_done,
                           remaining_shifts_done, busy}, 0);
    chk("async_rst_data", shift_data, 0);
    @(negedge clk);
    n_rst = 1'b1; dest_ready = 1'b0;
    @(negedge clk);
    run_pkt(m2, b2, 0, -1, -1);

    // Load pulsed with other data during MID is ignored.
    run_pkt(m1, b1, 0, -1, 4);

    // Back-to-back with load_valid held high.
    load_valid = 1'b1; dest_ready = 1'b1; midstate = m2; block_data = b2;
    ns = 0;
    for (int c = 0; c < 120 && ns < 3; c++) begin
      #1;
      if (start_found) begin
        starts[ns] = c;
        ns++;
      end
      @(negedge clk);
    end
    chk("b2b_starts_found", ns, 3);
    if (ns == 3) begin
      chk("b2b_spacing1", starts[1] - starts[0], 27);
      chk("b2b_spacing2", starts[2] - starts[1], 27);
    end
    load_valid = 1'b0;
    do_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
